indirect_csr_target: RTL and testbench

- Parametrised indirect-CSR responder: a DFH-headed CSR window with NUM_SCRATCH scratchpads and a live statistics register.
- Serves one 64-bit request at a time over a valid/ready request channel and a valid/ready response channel.
- Programmable response latency.
- Sits behind the indirect CSR bridge and acts as its standard target and unit-test endpoint.

---
 rtl/indirect_csr_target_pkg.sv | 36 +++
 rtl/csr_sat_cnt.sv | 36 +++
 rtl/indirect_csr_target.sv | 174 +++++++++++++++++
 tb/tb_indirect_csr_target.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/indirect_csr_target_pkg.sv
// ============================================================================
// Module   : indirect_csr_target_pkg
// Purpose  : Shared offsets, FSM encoding and STAT layout for indirect_csr_target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package indirect_csr_target_pkg;

  localparam int          DFH_OFS      = 'h0;
  localparam int          SCRATCH_BASE = 'h8;
  localparam int          UNUSED_OFS   = 'hFF8;
  localparam logic [63:0] DFH_DEFAULT  = 64'h3000_0000_1000_0020;
  localparam int          STAT_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] rsvd;
    logic [15:0] err_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
  } stat_t;

  // STAT sits immediately after the last scratchpad.
  function automatic int stat_ofs(input int num_scratch);
    return SCRATCH_BASE + 8 * num_scratch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_sat_cnt.sv
// ============================================================================
// Module   : csr_sat_cnt
// Purpose  : Saturating up-counter with synchronous clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/indirect_csr_target.sv
// ============================================================================
// Module   : indirect_csr_target
// Purpose  : DFH-headed CSR window with scratchpads, live STAT and programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module indirect_csr_target
  import indirect_csr_target_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          NUM_SCRATCH = 1,
  parameter int          RSP_LAT     = 1,
  parameter logic [63:0] DFH_VALUE   = DFH_DEFAULT,
  parameter logic [63:0] SCRATCH_RST = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [63:0]       i_req_wdata,
  input  logic [7:0]        i_req_be,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [63:0]       o_rsp_rdata,
  output logic              o_rsp_error
);

  localparam logic [ADDR_W-1:0] c_dfh_addr  = ADDR_W'(DFH_OFS);
  localparam logic [ADDR_W-1:0] c_stat_addr = ADDR_W'(stat_ofs(NUM_SCRATCH));
  localparam logic [1:0]        c_lat_init  = 2'(RSP_LAT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_lat;
  logic [63:0]           r_rdata;
  logic                  r_err;
  logic [63:0]           r_scratch [NUM_SCRATCH];

  logic                  w_req_ready;
  logic                  w_rsp_valid;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_dfh_hit;
  logic                  w_stat_hit;
  logic [NUM_SCRATCH-1:0] w_scr_hit;
  logic [63:0]           w_rd_data;
  logic                  w_wr_inc;
  logic                  w_rd_inc;
  logic                  w_err_inc;
  logic                  w_stat_clr;
  stat_t                 w_stat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (i_req_valid) w_next = (RSP_LAT == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_lat <= 2'd1) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = i_req_valid & w_req_ready;

  // ---------------------------------------------------------------- decode
  assign w_misalign = |i_req_addr[2:0];
  assign w_dfh_hit  = (i_req_addr == c_dfh_addr);
  assign w_stat_hit = (i_req_addr == c_stat_addr);

  generate
    for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scr_hit
      assign w_scr_hit[gi] = (i_req_addr == ADDR_W'(SCRATCH_BASE + 8 * gi));
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    if (w_dfh_hit)  w_rd_data = DFH_VALUE;
    if (w_stat_hit) w_rd_data = w_stat;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (w_scr_hit[i]) w_rd_data = r_scratch[i];
    end
  end

  // ---------------------------------------------------------------- scratchpads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= SCRATCH_RST;
    end else if (w_accept && i_req_write) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_scr_hit[i]) begin
          for (int k = 0; k < 8; k++) begin
            if (i_req_be[k]) r_scratch[i][8*k +: 8] <= i_req_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- STAT
  // A STAT write clears everything and is deliberately not counted itself.
  assign w_err_inc  = w_accept & w_misalign;
  assign w_stat_clr = w_accept & i_req_write & ~w_misalign & w_stat_hit;
  assign w_wr_inc   = w_accept & i_req_write & ~w_misalign & ~w_stat_hit;
  assign w_rd_inc   = w_accept & ~i_req_write & ~w_misalign;

  assign w_stat.rsvd = '0;

  csr_sat_cnt #(.WIDTH(STAT_CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_inc),
    .i_clr (w_stat_clr),
    .o_cnt (w_stat.wr_cnt)
  );

  csr_sat_cnt #(.WIDTH(STAT_CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_inc),
    .i_clr (w_stat_clr),
    .o_cnt (w_stat.rd_cnt)
  );

  csr_sat_cnt #(.WIDTH(STAT_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_err_inc),
    .i_clr (w_stat_clr),
    .o_cnt (w_stat.err_cnt)
  );

  // ---------------------------------------------------------------- response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_lat   <= c_lat_init;
      r_rdata <= i_req_write ? 64'h0 : w_rd_data;
      r_err   <= w_misalign;
    end else if (r_state == ST_WAIT) begin
      r_lat   <= r_lat - 2'd1;
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = w_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_error = r_err;

endmodule

`default_nettype wire

// File: tb/tb_indirect_csr_target.sv
// ============================================================================
// Module   : tb_indirect_csr_target
// Purpose  : Directed self-checking bench for indirect_csr_target (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_indirect_csr_target;

  localparam int N = 3;  // 0: defaults, 1: LAT4/NUM4, 2: LAT3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [11:0] req_addr  [N];
  logic [63:0] req_wdata [N];
  logic [7:0]  req_be    [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [63:0] rsp_rdata [N];
  logic        rsp_error [N];

  logic       sc_rst, sc_inc, sc_clr;
  logic [3:0] sc_cnt;

  indirect_csr_target u_a (
    .clk(clk), .rst(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_write(req_write[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .i_req_be(req_be[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_error(rsp_error[0]));

  indirect_csr_target #(.NUM_SCRATCH(4), .RSP_LAT(4)) u_b (
    .clk(clk), .rst(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_write(req_write[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .i_req_be(req_be[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_error(rsp_error[1]));

  indirect_csr_target #(.RSP_LAT(3)) u_c (
    .clk(clk), .rst(rst[2]), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_write(req_write[2]), .i_req_addr(req_addr[2]), .i_req_wdata(req_wdata[2]),
    .i_req_be(req_be[2]), .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]),
    .o_rsp_rdata(rsp_rdata[2]), .o_rsp_error(rsp_error[2]));

  csr_sat_cnt #(.WIDTH(4)) u_sc (
    .clk(clk), .rst(sc_rst), .i_inc(sc_inc), .i_clr(sc_clr), .o_cnt(sc_cnt));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high; lat = negedges from accept to rsp_valid.
  task automatic do_req(input int d, input logic wr, input logic [11:0] addr,
                        input logic [63:0] wd, input logic [7:0] be,
                        output logic [63:0] rd, output logic er, output int lat);
    int t;
    rd = '0; er = 1'b0; lat = 0; t = 0;
    while (req_ready[d] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (req_ready[d] !== 1'b1) begin
      chk("req_ready_timeout", 64'(req_ready[d]), 64'd1);
      return;
    end
    req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wd; req_be[d] = be;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid[d] !== 1'b1) begin
      chk("rsp_valid_timeout", 64'(rsp_valid[d]), 64'd1);
      return;
    end
    rd = rsp_rdata[d];
    er = rsp_error[d];
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [63:0] wd;
    logic [7:0]  be;
    logic [63:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          seen;

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b0;
    end
    sc_rst = 1'b1; sc_inc = 1'b0; sc_clr = 1'b0;

    tbl[0]  = '{1'b1, 12'h008, 64'hDEADBEEF_CAFEF00D, 8'h0F, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 12'h008, 64'h0, 8'h00, 64'h00000000_CAFEF00D, 1'b0};
    tbl[2]  = '{1'b0, 12'h010, 64'h0, 8'h00, 64'h0000_0000_0001_0001, 1'b0};
    tbl[3]  = '{1'b0, 12'hFF8, 64'h0, 8'h00, 64'h0, 1'b0};
    tbl[4]  = '{1'b0, 12'h009, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[5]  = '{1'b0, 12'h010, 64'h0, 8'h00, 64'h0000_0001_0003_0001, 1'b0};
    tbl[6]  = '{1'b1, 12'h008, 64'h11223344_55667788, 8'hF0, 64'h0, 1'b0};
    tbl[7]  = '{1'b0, 12'h008, 64'h0, 8'h00, 64'h11223344_CAFEF00D, 1'b0};
    tbl[8]  = '{1'b1, 12'h000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'h0, 1'b0};
    tbl[9]  = '{1'b0, 12'h000, 64'h0, 8'h00, 64'h3_00000_001000_0020, 1'b0};
    tbl[10] = '{1'b1, 12'hFF8, 64'h12345678_9ABCDEF0, 8'hFF, 64'h0, 1'b0};
    tbl[11] = '{1'b0, 12'hFF8, 64'h0, 8'h00, 64'h0, 1'b0};
    tbl[12] = '{1'b1, 12'h008, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 64'h0, 1'b0};
    tbl[13] = '{1'b1, 12'h00C, 64'hAAAAAAAA_AAAAAAAA, 8'hFF, 64'h0, 1'b1};
    tbl[14] = '{1'b0, 12'h008, 64'h0, 8'h00, 64'h11223344_CAFEF00D, 1'b0};
    tbl[15] = '{1'b0, 12'h010, 64'h0, 8'h00, 64'h0000_0002_0008_0005, 1'b0};
    tbl[16] = '{1'b1, 12'h010, 64'h0, 8'h00, 64'h0, 1'b0};
    tbl[17] = '{1'b0, 12'h010, 64'h0, 8'h00, 64'h0, 1'b0};
    tbl[18] = '{1'b0, 12'h010, 64'h0, 8'h00, 64'h0000_0000_0001_0000, 1'b0};

    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    sc_rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_req_ready", 64'(req_ready[0]), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 64'h0);
    chk("rst_rsp_error", 64'(rsp_error[0]), 64'd0);

    // DFH read and single-cycle latency
    do_req(0, 1'b0, 12'h000, 64'h0, 8'h00, rd, er, lat);
    chk("dfh_rdata", rd, 64'h3_00000_001000_0020);
    chk("dfh_error", 64'(er), 64'd0);
    chk("dfh_latency", 64'(lat), 64'd1);

    // Fresh STAT for the vector table
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;

    for (int v = 0; v < 19; v++) begin
      do_req(0, tbl[v].wr, tbl[v].addr, tbl[v].wd, tbl[v].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rd);
      chk($sformatf("vec%0d_error", v), 64'(er), 64'(tbl[v].exp_er));
    end

    // Write burst then STAT clear
    do_req(0, 1'b1, 12'h010, 64'h0, 8'hFF, rd, er, lat);
    for (int i = 0; i < 100; i++) do_req(0, 1'b1, 12'h008, 64'(i), 8'hFF, rd, er, lat);
    do_req(0, 1'b0, 12'h010, 64'h0, 8'h00, rd, er, lat);
    chk("burst_stat", rd, 64'h0000_0000_0000_0064);
    do_req(0, 1'b0, 12'h008, 64'h0, 8'h00, rd, er, lat);
    chk("burst_last_data", rd, 64'd99);
    do_req(0, 1'b1, 12'h010, 64'h0, 8'h5A, rd, er, lat);
    do_req(0, 1'b0, 12'h010, 64'h0, 8'h00, rd, er, lat);
    chk("stat_cleared", rd, 64'h0);

    // Config B: latency 4, backpressured response
    do_req(1, 1'b1, 12'h020, 64'h01234567_89ABCDEF, 8'hFF, rd, er, lat);
    chk("b_wr_latency", 64'(lat), 64'd4);
    chk("b_wr_rdata", rd, 64'h0);
    req_write[1] = 1'b0; req_addr[1] = 12'h020; req_be[1] = 8'h00;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("b_hold_valid_c%0d", c), 64'(rsp_valid[1]), (c >= 4) ? 64'd1 : 64'd0);
      chk($sformatf("b_hold_ready_c%0d", c), 64'(req_ready[1]), 64'd0);
      if (c >= 4) chk($sformatf("b_hold_rdata_c%0d", c), rsp_rdata[1], 64'h01234567_89ABCDEF);
      if (c < 10) @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("b_after_valid", 64'(rsp_valid[1]), 64'd0);
    chk("b_after_ready", 64'(req_ready[1]), 64'd1);
    do_req(1, 1'b0, 12'h028, 64'h0, 8'h00, rd, er, lat);
    chk("b_stat", rd, 64'h0000_0000_0001_0001);

    // Config C: reset while a request is in WAIT
    do_req(2, 1'b1, 12'h008, 64'hFEEDFACE_0BADF00D, 8'hFF, rd, er, lat);
    do_req(2, 1'b0, 12'h008, 64'h0, 8'h00, rd, er, lat);
    chk("c_rd_data", rd, 64'hFEEDFACE_0BADF00D);
    chk("c_latency", 64'(lat), 64'd3);
    req_write[2] = 1'b0; req_addr[2] = 12'h008; req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("c_wait_valid", 64'(rsp_valid[2]), 64'd0);
    rst[2] = 1'b1;
    #1;
    chk("c_rst_ready", 64'(req_ready[2]), 64'd1);
    chk("c_rst_valid", 64'(rsp_valid[2]), 64'd0);
    chk("c_rst_rdata", rsp_rdata[2], 64'h0);
    @(negedge clk);
    rst[2] = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[2] === 1'b1) seen++;
    end
    chk("c_no_stale_rsp", 64'(seen), 64'd0);
    do_req(2, 1'b0, 12'h008, 64'h0, 8'h00, rd, er, lat);
    chk("c_scratch_rst", rd, 64'h0);
    do_req(2, 1'b0, 12'h010, 64'h0, 8'h00, rd, er, lat);
    chk("c_stat_rst", rd, 64'h0000_0000_0001_0000);

    // Saturating counter
    sc_inc = 1'b1;
    repeat (20) @(negedge clk);
    chk("sat_hold_max", 64'(sc_cnt), 64'd15);
    sc_inc = 1'b0; sc_clr = 1'b1;
    @(negedge clk);
    chk("sat_clr", 64'(sc_cnt), 64'd0);
    sc_clr = 1'b0; sc_inc = 1'b1;
    repeat (3) @(negedge clk);
    chk("sat_count3", 64'(sc_cnt), 64'd3);
    sc_clr = 1'b1;
    @(negedge clk);
    chk("sat_clr_wins", 64'(sc_cnt), 64'd0);
    sc_inc = 1'b0; sc_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
